fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the Mini SRC datapath: owns the program counter, issues word reads to instruction memory over a ready handshake, and presents the fetched instruction and its successor address to the downstream branch/condition logic. It consumes the branch decision (redirect flag plus target) at the end of each instruction's execution and uses it to choose the next fetch address. It sits directly upstream of the branch logic and feeds `ir` and `pc_next` to it.

## Interface
- `AW`, 9: PC/memory word-address width (512-word memory).
- `RESET_PC`, 0: PC value loaded on reset.
- `HALT_OP`, 5'b11010: opcode (`ir[31:27]`) that stops fetching.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `mem_rd`  out  1  read request to instruction memory.
- `mem_addr`  out  AW  word address of the request.
- `mem_ready`  in  1  memory has `mem_rdata` valid this cycle.
- `mem_rdata`  in  32  instruction word.
- `ir`  out  32  current instruction register.
- `ir_valid`  out  1  `ir` holds an instruction awaiting execution.
- `ir_pc`  out  AW  address the current `ir` was fetched from.
- `pc_next`  out  AW  `ir_pc + 1` (mod 2^AW); base for branch offset.
- `exec_done`  in  1  one-cycle pulse: current instruction finished.
- `redirect`  in  1  branch/jump taken; qualified by `exec_done`.
- `redirect_pc`  in  AW  target address; qualified by `exec_done & redirect`.
- `halted`  out  1  halt instruction fetched; fetching stopped.
- `retired`  out  32  count of `exec_done` pulses accepted.

## Operation
- States: `S_RESET`, `S_REQ`, `S_WAIT`, `S_HOLD`, `S_HALT`.
- Reset (`reset_n`=0 at edge): state `S_RESET`; `pc`=`RESET_PC`; `ir`=0; `ir_pc`=0; `ir_valid`=0; `mem_rd`=0; `halted`=0; `retired`=0. Applies from any state, including mid-request; an outstanding read is abandoned and any later `mem_ready` is ignored.
- `S_RESET` -> `S_REQ` unconditionally on the first edge with `reset_n`=1.
- `S_REQ`/`S_WAIT`: `mem_rd`=1, `mem_addr`=`pc`, both held stable until `mem_ready` is sampled 1. `S_REQ` -> `S_WAIT` if `mem_ready`=0.
- On edge where `mem_rd`=1 and `mem_ready`=1: `ir`<=`mem_rdata`, `ir_pc`<=`pc`, `pc`<=`pc+1` (wraps 2^AW-1 -> 0), `mem_rd`<=0. Next state `S_HALT` if `mem_rdata[31:27]`==`HALT_OP`, else `S_HOLD`.
- `S_HOLD`: `ir_valid`=1. On `exec_done`: `retired`+=1 (wraps at 2^32); if `redirect`, `pc`<=`redirect_pc`, else `pc` unchanged; -> `S_REQ`.
- `S_HALT`: `halted`=1, `ir_valid`=0, `mem_rd`=0; exits only via reset. Halt is not counted in `retired`.
- `pc_next` = `ir_pc+1` mod 2^AW, combinational from `ir_pc`.
- Ignored inputs: `mem_ready` outside `S_REQ`/`S_WAIT`; `exec_done` outside `S_HOLD`; `redirect`/`redirect_pc` without `exec_done`.

## Timing
- All outputs registered except `pc_next` and `mem_addr` (driven from `pc`).
- Zero-wait memory (`mem_ready`=1 in first `S_REQ` cycle): `mem_rd` high 1 cycle; `ir_valid` high the following cycle.
- N wait cycles: `mem_rd` high N+1 cycles; `ir_valid` rises the cycle after the ready cycle.
- `exec_done` in cycle t: `ir_valid`=0 and `mem_rd`=1 with the new address in cycle t+1.
- Minimum instruction period with zero-wait memory and `exec_done` in the first `S_HOLD` cycle: 2 cycles.
- `ir` is stable from the load edge until the next load; it is not cleared on `exec_done`.

## Structure
- Shared package `src_pkg`: state enum, opcode constants including `HALT_OP`, and the default for `AW`.
- One sub-module: `pc_counter`. It holds load/increment/wrap with reset to `RESET_PC`.
- FSM, IR register, and retired counter live in `fetch_unit`.

## Test plan
- Reset then zero-wait memory returning 0x0800_0000 at addr 0: `mem_rd` at cycle 1 with `mem_addr`=0; `ir`=0x0800_0000, `ir_valid`=1, `ir_pc`=0, `pc_next`=1 at cycle 2.
- `mem_ready` delayed 3 cycles: `mem_rd`/`mem_addr` held 4 cycles unchanged; `ir` loads on the 4th cycle.
- `exec_done`+`redirect` with `redirect_pc`=0x1F0: next `mem_addr`=0x1F0, `retired` increments by 1. `exec_done` without redirect: `mem_addr`=`ir_pc+1`.
- PC wrap: fetch at 0x1FF with no redirect: `pc_next`=0, next `mem_addr`=0.
- Fetch of word with opcode 5'b11010: `halted`=1, `ir_valid`=0, no further `mem_rd`, and `exec_done` pulses do not change `retired`.
- `reset_n` low during `S_WAIT`, then late `mem_ready`=1: `mem_rd`=0, `ir`=0, and the next request goes to `RESET_PC`.

Source files
------------

// File: rtl/src_pkg.sv
// Shared definitions for the Mini SRC datapath: fetch FSM states, opcode
// constants and the default address width.
package src_pkg;

  localparam int AW_DEFAULT = 9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input logic [31:0] instr);
    return instr[31:27];
  endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: load has priority over increment, increment
// wraps modulo 2^AW, synchronous active-low reset to RESET_PC.
module pc_counter
  import src_pkg::*;
#(
  parameter int            AW       = AW_DEFAULT,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  // PC update: reset, redirect load, or post-fetch increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, ready-handshake word reads, IR
// register, halt detection and retired-instruction counter.
module fetch_unit
  import src_pkg::*;
#(
  parameter int            AW       = AW_DEFAULT,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}},
  parameter logic [4:0]    HALT_OP  = OP_HALT
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   ir,
  output logic          ir_valid,
  output logic [AW-1:0] ir_pc,
  output logic [AW-1:0] pc_next,
  input  logic          exec_done,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted,
  output logic [31:0]   retired
);

  fetch_state_e  state_r;
  logic          pc_load_s;
  logic          pc_inc_s;
  logic [AW-1:0] pc_s;

  pc_counter #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (pc_load_s),
    .load_val (redirect_pc),
    .inc      (pc_inc_s),
    .pc       (pc_s)
  );

  assign mem_addr = pc_s;
  assign pc_next  = ir_pc + {{(AW-1){1'b0}}, 1'b1};

  // PC control: step past a completed read, load on a taken branch.
  always_comb begin
    pc_load_s = 1'b0;
    pc_inc_s  = 1'b0;
    case (state_r)
      S_REQ, S_WAIT: pc_inc_s  = mem_ready;
      S_HOLD:        pc_load_s = exec_done & redirect;
      default: begin
        pc_load_s = 1'b0;
        pc_inc_s  = 1'b0;
      end
    endcase
  end

  // Fetch FSM with registered handshake, IR, status and retire counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= S_RESET;
      ir       <= 32'h0000_0000;
      ir_pc    <= {AW{1'b0}};
      ir_valid <= 1'b0;
      mem_rd   <= 1'b0;
      halted   <= 1'b0;
      retired  <= 32'd0;
    end else begin
      case (state_r)
        S_RESET: begin
          state_r <= S_REQ;
          mem_rd  <= 1'b1;
        end
        S_REQ, S_WAIT: begin
          if (mem_ready) begin
            ir     <= mem_rdata;
            ir_pc  <= pc_s;
            mem_rd <= 1'b0;
            if (opcode_of(mem_rdata) == HALT_OP) begin
              state_r  <= S_HALT;
              halted   <= 1'b1;
              ir_valid <= 1'b0;
            end else begin
              state_r  <= S_HOLD;
              ir_valid <= 1'b1;
            end
          end else begin
            state_r <= S_WAIT;
            mem_rd  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (exec_done) begin
            retired  <= retired + 32'd1;
            ir_valid <= 1'b0;
            mem_rd   <= 1'b1;
            state_r  <= S_REQ;
          end else begin
            state_r <= S_HOLD;
          end
        end
        S_HALT: begin
          halted   <= 1'b1;
          ir_valid <= 1'b0;
          mem_rd   <= 1'b0;
        end
        default: begin
          state_r  <= S_RESET;
          ir_valid <= 1'b0;
          mem_rd   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random memory contents, wait states,
// execution delays and redirects checked against an instruction-level model.
module tb_fetch_unit;

  localparam int AW = 9;
  localparam int MEM_WORDS = 512;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [31:0]   ir;
  logic          ir_valid;
  logic [AW-1:0] ir_pc;
  logic [AW-1:0] pc_next;
  logic          exec_done;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halted;
  logic [31:0]   retired;

  int checks = 0;
  int errors = 0;

  // Model state: instruction memory, next fetch address, retire count, last IR.
  logic [31:0] mem [0:MEM_WORDS-1];
  int          exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] last_ir;

  fetch_unit #(.AW(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_pc       (ir_pc),
    .pc_next     (pc_next),
    .exec_done   (exec_done),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == 5'b11010) w[31:27] = 5'b00001;
    return w;
  endfunction

  task automatic reset_dut();
    reset_n = 1'b0; mem_ready = 1'b0; exec_done = 1'b0; redirect = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_pc = 0; exp_ret = 32'd0; last_ir = 32'h0;
  endtask

  // One instruction read with the given number of not-ready cycles.
  task automatic do_fetch(input int waits);
    logic [31:0] word;
    bit          is_halt;
    word    = mem[exp_pc];
    is_halt = (word[31:27] == 5'b11010);
    checks++; if (mem_rd !== 1'b1 || mem_addr !== AW'(exp_pc)) begin errors++;
      $display("FAIL fetch_req got rd=%0b addr=%h exp rd=1 addr=%h", mem_rd, mem_addr, AW'(exp_pc)); end
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0; mem_rdata = $urandom; exec_done = 1'($urandom);
      redirect = 1'($urandom); redirect_pc = AW'($urandom);
      tick();
      checks++; if (mem_rd !== 1'b1 || mem_addr !== AW'(exp_pc) || ir !== last_ir) begin errors++;
        $display("FAIL wait_hold got rd=%0b addr=%h ir=%h exp rd=1 addr=%h ir=%h",
                 mem_rd, mem_addr, ir, AW'(exp_pc), last_ir); end
    end
    mem_ready = 1'b1; mem_rdata = word; exec_done = 1'($urandom);
    tick();
    mem_ready = 1'b0; exec_done = 1'b0; redirect = 1'b0; mem_rdata = $urandom;
    checks++; if (mem_rd !== 1'b0) begin errors++;
      $display("FAIL fetch_rd_drop got %0b exp 0", mem_rd); end
    checks++; if (ir !== word || ir_pc !== AW'(exp_pc)) begin errors++;
      $display("FAIL ir_load got ir=%h ir_pc=%h exp ir=%h ir_pc=%h", ir, ir_pc, word, AW'(exp_pc)); end
    checks++; if (ir_valid !== !is_halt || halted !== is_halt) begin errors++;
      $display("FAIL ir_status got valid=%0b halted=%0b exp valid=%0b halted=%0b",
               ir_valid, halted, !is_halt, is_halt); end
    checks++; if (pc_next !== AW'((exp_pc + 1) % MEM_WORDS)) begin errors++;
      $display("FAIL pc_next got %h exp %h", pc_next, AW'((exp_pc + 1) % MEM_WORDS)); end
    last_ir = word;
    exp_pc  = (exp_pc + 1) % MEM_WORDS;
  endtask

  // Execution of the held instruction after `delay` idle cycles.
  task automatic do_exec(input int delay, input bit redir, input int target);
    for (int i = 0; i < delay; i++) begin
      exec_done = 1'b0; redirect = 1'($urandom); redirect_pc = AW'($urandom);
      mem_ready = 1'($urandom);
      tick();
      checks++; if (ir_valid !== 1'b1 || mem_rd !== 1'b0 || retired !== exp_ret) begin errors++;
        $display("FAIL hold_idle got valid=%0b rd=%0b retired=%0d exp valid=1 rd=0 retired=%0d",
                 ir_valid, mem_rd, retired, exp_ret); end
    end
    exec_done = 1'b1; redirect = redir; redirect_pc = AW'(target); mem_ready = 1'($urandom);
    tick();
    exec_done = 1'b0; redirect = 1'b0; mem_ready = 1'b0;
    exp_ret = exp_ret + 32'd1;
    if (redir) exp_pc = target % MEM_WORDS;
    checks++; if (ir_valid !== 1'b0 || mem_rd !== 1'b1) begin errors++;
      $display("FAIL exec_next got valid=%0b rd=%0b exp valid=0 rd=1", ir_valid, mem_rd); end
    checks++; if (mem_addr !== AW'(exp_pc)) begin errors++;
      $display("FAIL exec_addr got %h exp %h", mem_addr, AW'(exp_pc)); end
    checks++; if (retired !== exp_ret || ir !== last_ir) begin errors++;
      $display("FAIL exec_retire got retired=%0d ir=%h exp retired=%0d ir=%h",
               retired, ir, exp_ret, last_ir); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'($urandom); mem_rdata = $urandom;
    exec_done = 1'($urandom); redirect = 1'($urandom); redirect_pc = AW'($urandom);
    tick(); tick();
    checks++; if (mem_rd !== 1'b0 || ir !== 32'h0 || ir_valid !== 1'b0 || halted !== 1'b0) begin errors++;
      $display("FAIL reset_outputs got rd=%0b ir=%h valid=%0b halted=%0b exp all zero",
               mem_rd, ir, ir_valid, halted); end
    checks++; if (ir_pc !== 9'h000 || retired !== 32'd0 || pc_next !== 9'h001) begin errors++;
      $display("FAIL reset_counters got ir_pc=%h retired=%0d pc_next=%h exp 0 0 1", ir_pc, retired, pc_next); end
    reset_n = 1'b1; mem_ready = 1'b0; exec_done = 1'b0;
    tick();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 9'h000) begin errors++;
      $display("FAIL reset_first_req got rd=%0b addr=%h exp rd=1 addr=000", mem_rd, mem_addr); end
    exp_pc = 0; exp_ret = 32'd0; last_ir = 32'h0;
  endtask

  task automatic test_zero_wait();
    reset_dut();
    mem[0] = 32'h0800_0000;
    do_fetch(0);
    do_exec(0, 1'b0, 0);
    do_fetch(0);
    do_exec(0, 1'b0, 0);
  endtask

  task automatic test_wait_states();
    do_fetch(3);
    do_exec(2, 1'b0, 0);
  endtask

  task automatic test_redirect();
    do_fetch(1);
    do_exec(1, 1'b1, 'h1F0);
    do_fetch(0);
    do_exec(0, 1'b0, 0);
  endtask

  task automatic test_wrap();
    do_fetch(0);
    do_exec(0, 1'b1, 'h1FF);
    do_fetch(2);
    do_exec(1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_fetch($urandom_range(0, 3));
      do_exec($urandom_range(0, 2), 1'($urandom), $urandom_range(0, MEM_WORDS - 1));
    end
  endtask

  task automatic test_halt();
    logic [31:0] saved;
    int          addr;
    addr  = exp_pc;
    saved = mem[addr];
    mem[addr] = {5'b11010, 27'($urandom)};
    do_fetch($urandom_range(0, 2));
    for (int i = 0; i < 6; i++) begin
      exec_done = (i % 2 == 0); redirect = 1'($urandom); redirect_pc = AW'($urandom);
      mem_ready = 1'($urandom); mem_rdata = $urandom;
      tick();
      checks++; if (halted !== 1'b1 || ir_valid !== 1'b0 || mem_rd !== 1'b0 || retired !== exp_ret) begin errors++;
        $display("FAIL halt_stay got halted=%0b valid=%0b rd=%0b retired=%0d exp 1 0 0 %0d",
                 halted, ir_valid, mem_rd, retired, exp_ret); end
    end
    exec_done = 1'b0; mem_ready = 1'b0;
    mem[addr] = saved;
  endtask

  task automatic test_reset_mid_wait();
    reset_dut();
    do_fetch(0);
    do_exec(0, 1'b1, 'h0A5);
    mem_ready = 1'b0;
    tick(); tick();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 9'h0A5) begin errors++;
      $display("FAIL midwait_req got rd=%0b addr=%h exp rd=1 addr=0a5", mem_rd, mem_addr); end
    reset_n = 1'b0;
    tick();
    checks++; if (mem_rd !== 1'b0 || ir !== 32'h0 || retired !== 32'd0) begin errors++;
      $display("FAIL midwait_reset got rd=%0b ir=%h retired=%0d exp 0 0 0", mem_rd, ir, retired); end
    reset_n = 1'b1; mem_ready = 1'b1; mem_rdata = rand_word();
    tick();
    mem_ready = 1'b0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 9'h000 || ir !== 32'h0 || ir_valid !== 1'b0) begin errors++;
      $display("FAIL late_ready got rd=%0b addr=%h ir=%h valid=%0b exp 1 000 0 0",
               mem_rd, mem_addr, ir, ir_valid); end
    exp_pc = 0; exp_ret = 32'd0; last_ir = 32'h0;
    do_fetch(1);
    do_exec(0, 1'b0, 0);
  endtask

  initial begin
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = rand_word();
    reset_n = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    exec_done = 1'b0; redirect = 1'b0; redirect_pc = 9'h000;
    exp_pc = 0; exp_ret = 32'd0; last_ir = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid_wait();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
